// File: rtl/seg7_scan_display_if.sv
// Host-side bundle for the multiplexed seven-segment display controller:
// display data and control in, scanned anode/segment drive and frame strobe out.
interface seg7_scan_display_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp;
   logic                  blank_lz;
   logic [DIGITS-1:0]     an;
   logic [7:0]            seg;
   logic                  frame_tick;

   modport master (
      output enable, load, value, dp, blank_lz,
      input  an, seg, frame_tick
   );

   modport slave (
      input  enable, load, value, dp, blank_lz,
      output an, seg, frame_tick
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed DIGITS-digit seven-segment scanner with a frame-synchronous
// shadow register, per-digit decimal points and leading-zero blanking.
module seg7_scan_display #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   seg7_scan_display_if.slave  bus
);

   localparam int                CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};
   localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
   logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
   logic                pend_q, pend_d;
   logic                tick_q, tick_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;

   logic                scan_end, wrap, blank;
   logic [3:0]          nib;
   logic [DIGITS-1:0]   an_hot;
   logic [7:0]          seg_on;

   always_comb begin
      scan_end = bus.enable && (cnt_q == CNT_LAST);
      wrap     = scan_end && (idx_q == IDX_LAST);
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      if (bus.enable) begin
         if (scan_end) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // A load coinciding with a wrap still lands in the shadow and stays pending,
   // so the wrap moves the previous shadow contents and never a half-new frame.
   always_comb begin
      sh_val_d   = bus.load ? bus.value : sh_val_q;
      sh_dp_d    = bus.load ? bus.dp : sh_dp_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      if (wrap && pend_q) begin
         disp_val_d = sh_val_q;
         disp_dp_d  = sh_dp_q;
      end
      pend_d = bus.load | (pend_q & ~wrap);
      tick_d = wrap;
   end

   // Digit idx is blank when it and every more-significant nibble are zero.
   always_comb begin
      nib   = disp_val_q[4*int'(idx_q) +: 4];
      blank = bus.blank_lz && (idx_q != '0);
      for (int j = 0; j < DIGITS; j++) begin
         if (j >= int'(idx_q) && disp_val_q[4*j +: 4] != 4'h0) blank = 1'b0;
      end
      seg_on = {disp_dp_q[idx_q], blank ? 7'h00 : hex7(nib)};
      an_hot = DIGITS'(1) << idx_q;
      an_d   = bus.enable ? (AN_ACTIVE_LOW ? ~an_hot : an_hot) : AN_OFF;
      seg_d  = bus.enable ? (SEG_ACTIVE_LOW ? ~seg_on : seg_on) : SEG_OFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_val_q   <= '0;
         sh_dp_q    <= '0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         pend_q     <= 1'b0;
         tick_q     <= 1'b0;
         an_q       <= AN_OFF;
         seg_q      <= SEG_OFF;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_val_q   <= sh_val_d;
         sh_dp_q    <= sh_dp_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         pend_q     <= pend_d;
         tick_q     <= tick_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multiplexed seven-segment display controller for the board debug display (an/seg outputs of the CPU top).
- Generalises the fixed 4-digit hex display to DIGITS digits, with configurable scan rate and output polarity, per-digit decimal points and leading-zero blanking.
- A frame-synchronous shadow register prevents torn digits when the CPU or switch logic updates the value mid-scan.

Parameters:
- DIGITS, 4, number of digits (1..8).
- SCAN_DIV, 50000, clk cycles each digit stays lit (>=1).
- AN_ACTIVE_LOW, 1, 1 = anode enable driven low.
- SEG_ACTIVE_LOW, 1, 1 = segment and dp lit when low.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scanning and display on.
- load  in  1  one-cycle strobe; captures value and dp into the shadow register.
- value  in  4*DIGITS  hex nibbles; nibble i is shown on digit i (digit 0 is rightmost).
- dp  in  DIGITS  decimal point per digit; 1 = lit.
- blank_lz  in  1  1 = blank leading zero digits.
- an  out  DIGITS  digit enables, one-hot in the active polarity.
- seg  out  8  seg[7] = dp, seg[6:0] = g..a.
- frame_tick  out  1  one-cycle pulse when the scan wraps from DIGITS-1 to 0.

Behaviour:
- Reset (async assert, sync release) clears:
  - prescaler, digit index, display register, shadow register, pending flag and frame_tick to 0.
  - an to all-inactive (all 1 when AN_ACTIVE_LOW).
  - seg to all-unlit (8'hFF when SEG_ACTIVE_LOW).
- Prescaler:
  - Counts 0..SCAN_DIV-1 while enable=1.
  - At SCAN_DIV-1 it returns to 0 and the digit index increments, wrapping DIGITS-1 to 0.
  - With SCAN_DIV=1 the index advances every cycle.
- enable=0: prescaler and index hold; an and seg go inactive on the next edge. Re-enabling resumes at the held digit.
- frame_tick is registered and high for exactly the cycle following the DIGITS-1 to 0 index wrap.
- Shadow register and pending flag:
  - load=1 writes {value, dp} to the shadow register and sets pending.
  - At each index wrap with pending=1, the display register takes the shadow contents and pending clears.
  - The display register never changes mid-frame.
- load in the same cycle as a wrap:
  - The wrap transfers the old shadow contents.
  - The new data enters the shadow register and pending stays 1, so it applies at the following wrap.
- Output timing: an and seg are registered from the current index and display register, so they lag an index change by 1 cycle.
- Hex decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - seg[7] = dp bit of the current digit.
  - The whole byte is inverted when SEG_ACTIVE_LOW.
- Leading-zero blanking:
  - With blank_lz=1, digit i>0 is blanked when nibbles i..DIGITS-1 are all zero.
  - Blanking forces segments g..a unlit; the dp bit still follows dp.
  - Digit 0 is never blanked.
- Anode of the current digit is asserted even when that digit is blanked.
- Reset asserted mid-frame clears immediately, including any pending load. No partial frame follows reset release; scanning restarts at digit 0.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4 and active-low outputs.
- Reset: rst_n=0 at any point mid-scan -> an=4'hF, seg=8'hFF, frame_tick=0 with no clock edge required. After release, digit 0 lights first.
- Scan order: enable=1, value=0, blank_lz=0 -> an cycles 1110,1101,1011,0111, each held 4 cycles; seg=C0 on every digit; frame_tick pulses once per 16 cycles.
- Load and decode: value=16'h12AF, dp=4'b0001, then the next frame_tick -> digit0 seg=0E, digit1 seg=88, digit2 seg=A4, digit3 seg=F9.
- Anti-tearing:
  - load 16'h1111 while digit 1 is lit -> all digits keep the old value until the frame_tick.
  - load coinciding with a wrap -> the value appears one frame later.
- Leading-zero blanking, blank_lz=1:
  - value 16'h0050 -> digits 3 and 2 seg=FF, digit1 seg=92, digit0 seg=C0.
  - value 16'h0000 -> only digit0 shows C0.
  - dp=4'b1000 with value 16'h0000 -> digit3 seg=7F.
- Enable gating: enable=0 during digit 2 -> an=F, seg=FF on the next cycle, no frame_tick. enable=1 -> digit 2 resumes with the remaining prescaler count.
